// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution for a 16-bit core: evaluates branch
// conditions against bypassed flags, selects the next PC and produces a flush pulse.
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [15:0] instr,
  input  logic [15:0] rs_data,
  input  logic [2:0]  flags_q,
  input  logic [2:0]  flag_wen,
  input  logic [2:0]  flag_in,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic        flush,
  output logic        halted
);

  // Handshake: none. The unit advances one instruction per cycle whenever
  // stall is low; stall=1 freezes the PC, the FSM and flush generation.

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic        r_flush;
  logic        w_flush_nxt;

  logic [3:0]  w_opcode;
  logic [2:0]  w_ccc;
  logic [8:0]  w_imm9;
  logic [2:0]  w_eff;
  logic        w_z;
  logic        w_v;
  logic        w_n;
  logic        w_cond;
  logic        w_is_branch;
  logic        w_is_hlt;
  logic [15:0] w_offset;
  logic [15:0] w_target;

  assign w_opcode = instr[15:12];
  assign w_ccc    = instr[11:9];
  assign w_imm9   = instr[8:0];

  // Flags written in this same cycle take precedence over the register copy.
  assign w_eff = (flag_wen & flag_in) | (~flag_wen & flags_q);
  assign w_z   = w_eff[2];
  assign w_v   = w_eff[1];
  assign w_n   = w_eff[0];

  always_comb begin
    w_cond = 1'b0;
    case (w_ccc)
      3'b000:  w_cond = ~w_z;
      3'b001:  w_cond = w_z;
      3'b010:  w_cond = ~w_z & ~w_n;
      3'b011:  w_cond = w_n;
      3'b100:  w_cond = w_z | ~w_n;
      3'b101:  w_cond = w_z | w_n;
      3'b110:  w_cond = w_v;
      default: w_cond = 1'b1;
    endcase
  end

  assign w_is_branch = (w_opcode == OP_B) || (w_opcode == OP_BR);
  assign w_is_hlt    = (w_opcode == OP_HLT);

  assign pc_plus2 = r_pc + 16'd2;
  assign w_offset = {{6{w_imm9[8]}}, w_imm9, 1'b0};
  assign w_target = (w_opcode == OP_BR) ? rs_data : (pc_plus2 + w_offset);

  assign taken = w_is_branch & w_cond & (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flush_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!stall) begin
          w_flush_nxt = taken;
          if (taken) begin
            w_pc_nxt = w_target;
          end else if (w_is_hlt) begin
            // PC stays on the HLT so it reports where execution stopped.
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_nxt = pc_plus2;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  assign pc_out = r_pc;
  assign flush  = r_flush;
  assign halted = (r_state == ST_HALTED);

endmodule
